// File: rtl/dca_step_inst_generator_pkg.sv
// Shared definitions for the DCA step instruction generator: opcode bit indices, FSM states.
// DCA_STEP_GEN_BIAS_PRELOAD_EN adds the PRELOAD state.
package dca_step_inst_generator_pkg;

  localparam int BW_DCA_NEUGEMM_OPCODE              = 5;
  localparam int DCA_NEUGEMM_OPCODE_INDEX_LSU0_REQ  = 0;
  localparam int DCA_NEUGEMM_OPCODE_INDEX_LSU1_REQ  = 1;
  localparam int DCA_NEUGEMM_OPCODE_INDEX_LSU2_REQ  = 2;
  localparam int DCA_NEUGEMM_OPCODE_INDEX_LOAD_ACC  = 3;
  localparam int DCA_NEUGEMM_OPCODE_INDEX_NO_CAL    = 4;

`ifdef DCA_STEP_GEN_BIAS_PRELOAD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1, S_PRELOAD = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1} state_e;
`endif

endpackage

// File: rtl/dca_step_inst_generator_opcode_builder.sv
// Combinational opcode builder: step position and tile flags -> neugemm opcode.
module dca_step_inst_opcode_builder
  import dca_step_inst_generator_pkg::*;
(
  input  logic                             is_first_i,
  input  logic                             is_last_i,
  input  logic                             load_acc_i,
  input  logic                             store_i,
  input  logic                             preload_i,
  output logic [BW_DCA_NEUGEMM_OPCODE-1:0] opcode_o
);

  // Preload inst only loads the accumulator; compute steps always fetch both operands.
  always_comb begin
    opcode_o = '0;
    if (preload_i) begin
      opcode_o[DCA_NEUGEMM_OPCODE_INDEX_NO_CAL]   = 1'b1;
      opcode_o[DCA_NEUGEMM_OPCODE_INDEX_LOAD_ACC] = 1'b1;
    end else begin
      opcode_o[DCA_NEUGEMM_OPCODE_INDEX_LSU0_REQ] = 1'b1;
      opcode_o[DCA_NEUGEMM_OPCODE_INDEX_LSU1_REQ] = 1'b1;
      opcode_o[DCA_NEUGEMM_OPCODE_INDEX_LOAD_ACC] = load_acc_i & is_first_i;
      opcode_o[DCA_NEUGEMM_OPCODE_INDEX_LSU2_REQ] = store_i & is_last_i;
    end
  end

endmodule

// File: rtl/dca_step_inst_generator.sv
// Expands one GEMM tile command into per-K-step instructions on a registered valid/ready link.
// Optional bias preload step is enabled by defining DCA_STEP_GEN_BIAS_PRELOAD_EN.
module dca_step_inst_generator
  import dca_step_inst_generator_pkg::*;
#(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_STEP_COUNT    = 16,
  parameter int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA,
  parameter int MATRIX_NUM_COL   = MATRIX_SIZE_PARA,
  parameter int BW_BLOCKED_STEP_INST = MATRIX_NUM_ROW + MATRIX_NUM_COL + 1 + BW_DCA_NEUGEMM_OPCODE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [BW_STEP_COUNT-1:0]        cmd_num_step,
  input  logic [MATRIX_NUM_ROW-1:0]       cmd_row_mask,
  input  logic [MATRIX_NUM_COL-1:0]       cmd_col_mask,
  input  logic                            cmd_load_acc,
  input  logic                            cmd_store,
  input  logic                            cmd_bias,
  output logic                            inst_valid,
  input  logic                            inst_ready,
  output logic [BW_BLOCKED_STEP_INST-1:0] inst,
  output logic                            busy,
  output logic                            done
);

  localparam logic [BW_STEP_COUNT-1:0] STEP_ONE = {{(BW_STEP_COUNT-1){1'b0}}, 1'b1};

  state_e                            state_q, state_d;
  logic [BW_STEP_COUNT-1:0]          rem_q, rem_d;
  logic                              load_acc_q, load_acc_d;
  logic                              store_q, store_d;
  logic [MATRIX_NUM_ROW-1:0]         row_q, row_d;
  logic [MATRIX_NUM_COL-1:0]         col_q, col_d;
  logic [BW_BLOCKED_STEP_INST-1:0]   inst_q, inst_d;
  logic                              inst_valid_q, inst_valid_d;
  logic                              done_q, done_d;

  logic                              hs_s;
  logic                              gen_en_s, gen_first_s, gen_last_s, gen_preload_s;
  logic                              gen_load_acc_s, gen_store_s;
  logic [MATRIX_NUM_ROW-1:0]         gen_row_s;
  logic [MATRIX_NUM_COL-1:0]         gen_col_s;
  logic [BW_DCA_NEUGEMM_OPCODE-1:0]  opcode_s;

`ifndef DCA_STEP_GEN_BIAS_PRELOAD_EN
  logic unused_bias_s;
  assign unused_bias_s = cmd_bias;
`endif

  assign hs_s = inst_valid_q & inst_ready;

  dca_step_inst_opcode_builder u_opcode_builder (
    .is_first_i (gen_first_s),
    .is_last_i  (gen_last_s),
    .load_acc_i (gen_load_acc_s),
    .store_i    (gen_store_s),
    .preload_i  (gen_preload_s),
    .opcode_o   (opcode_s)
  );

  // rem_q holds the number of steps not yet loaded into the output register; 0 means the inst
  // currently on the link is the last one of the tile.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    load_acc_d     = load_acc_q;
    store_d        = store_q;
    row_d          = row_q;
    col_d          = col_q;
    inst_d         = inst_q;
    inst_valid_d   = hs_s ? 1'b0 : inst_valid_q;
    done_d         = 1'b0;
    gen_en_s       = 1'b0;
    gen_first_s    = 1'b0;
    gen_last_s     = 1'b0;
    gen_preload_s  = 1'b0;
    gen_load_acc_s = load_acc_q;
    gen_store_s    = store_q;
    gen_row_s      = row_q;
    gen_col_s      = col_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          row_d          = cmd_row_mask;
          col_d          = cmd_col_mask;
          load_acc_d     = cmd_load_acc;
          store_d        = cmd_store;
          gen_row_s      = cmd_row_mask;
          gen_col_s      = cmd_col_mask;
          gen_load_acc_s = cmd_load_acc;
          gen_store_s    = cmd_store;
`ifdef DCA_STEP_GEN_BIAS_PRELOAD_EN
          if (cmd_bias) begin
            gen_en_s      = 1'b1;
            gen_preload_s = 1'b1;
            gen_last_s    = (cmd_num_step == '0);
            load_acc_d    = 1'b0;
            rem_d         = cmd_num_step;
            state_d       = S_PRELOAD;
          end else
`endif
          if (cmd_num_step == '0) begin
            done_d = 1'b1;
          end else begin
            gen_en_s    = 1'b1;
            gen_first_s = 1'b1;
            gen_last_s  = (cmd_num_step == STEP_ONE);
            rem_d       = cmd_num_step - STEP_ONE;
            state_d     = S_STEP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef DCA_STEP_GEN_BIAS_PRELOAD_EN
      S_PRELOAD: begin
        if (hs_s && rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (hs_s) begin
          gen_en_s    = 1'b1;
          gen_first_s = 1'b1;
          gen_last_s  = (rem_q == STEP_ONE);
          rem_d       = rem_q - STEP_ONE;
          state_d     = S_STEP;
        end else begin
          state_d = S_PRELOAD;
        end
      end
`endif
      S_STEP: begin
        if (hs_s && rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (hs_s) begin
          gen_en_s   = 1'b1;
          gen_last_s = (rem_q == STEP_ONE);
          rem_d      = rem_q - STEP_ONE;
        end else begin
          state_d = S_STEP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (gen_en_s) begin
      inst_d       = {gen_row_s, gen_col_s, gen_last_s, opcode_s};
      inst_valid_d = 1'b1;
    end else begin
      inst_d = inst_d;
    end

    // Abort wins over any handshake or command in the same cycle.
    if (clear) begin
      state_d      = S_IDLE;
      rem_d        = '0;
      inst_valid_d = 1'b0;
      done_d       = 1'b0;
    end else begin
      done_d = done_d;
    end
  end

  // State, counter, latched command fields and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      load_acc_q   <= 1'b0;
      store_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      load_acc_q   <= load_acc_d;
      store_q      <= store_d;
      row_q        <= row_d;
      col_q        <= col_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dca_step_inst_generator.sv
// Randomized self-checking bench for dca_step_inst_generator with a queue-based tile model.
module tb_dca_step_inst_generator;

  localparam int IW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [15:0]   cmd_num_step = 16'd0;
  logic [7:0]    cmd_row_mask = 8'd0;
  logic [7:0]    cmd_col_mask = 8'd0;
  logic          cmd_load_acc = 1'b0;
  logic          cmd_store = 1'b0;
  logic          cmd_bias = 1'b0;
  logic          inst_valid;
  logic          inst_ready = 1'b1;
  logic [IW-1:0] inst;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_fail = 0;

  logic [IW-1:0] exp_q[$];
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic          prev_hold = 1'b0;
  logic [IW-1:0] prev_inst = '0;

  dca_step_inst_generator dut (
    .clk(clk), .rst(rst), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_step(cmd_num_step),
    .cmd_row_mask(cmd_row_mask), .cmd_col_mask(cmd_col_mask),
    .cmd_load_acc(cmd_load_acc), .cmd_store(cmd_store), .cmd_bias(cmd_bias),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Opcode bits: [4]=NO_CAL [3]=LOAD_ACC [2]=LSU2 [1]=LSU1 [0]=LSU0
  task automatic model_accept(input int n, input logic [7:0] row, input logic [7:0] col,
                              input logic la, input logic st, input logic bias);
    logic [4:0] op;
    logic       la_eff;
    la_eff = la;
`ifdef DCA_STEP_GEN_BIAS_PRELOAD_EN
    if (bias) begin
      exp_q.push_back({row, col, (n == 0), 5'b11000});
      la_eff = 1'b0;
    end
`else
    if (bias) la_eff = la;
`endif
    for (int k = 0; k < n; k++) begin
      op = 5'b00011;
      if (la_eff && k == 0) op = op | 5'b01000;
      if (st && k == n - 1) op = op | 5'b00100;
      exp_q.push_back({row, col, (k == n - 1), op});
    end
  endtask

  // Per-cycle compare against the model, then advance the model with this cycle's events.
  always @(negedge clk) begin
    logic busy_before, hs, popped_last;
    if (rst) begin
      exp_q.delete();
      exp_busy = 1'b0;
      exp_done = 1'b0;
      prev_hold = 1'b0;
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, '0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
    end else begin
      check("done", done, exp_done);
      check("busy", busy, exp_busy);
      check("cmd_ready", cmd_ready, !exp_busy);
      check("inst_valid", inst_valid, exp_q.size() != 0);
      if (prev_hold && inst_valid) check("inst_stable", inst, prev_inst);
      busy_before = exp_busy;
      exp_done = 1'b0;
      popped_last = 1'b0;
      hs = inst_valid && inst_ready;
      if (hs && exp_q.size() != 0) begin
        check("inst", inst, exp_q[0]);
        void'(exp_q.pop_front());
        popped_last = (exp_q.size() == 0);
      end
      if (clear) begin
        exp_q.delete();
        exp_busy = 1'b0;
      end else begin
        if (popped_last && busy_before) begin
          exp_done = 1'b1;
          exp_busy = 1'b0;
        end
        if (cmd_valid && !busy_before) begin
          model_accept(int'(cmd_num_step), cmd_row_mask, cmd_col_mask, cmd_load_acc, cmd_store, cmd_bias);
          if (exp_q.size() == 0) exp_done = 1'b1;
          else exp_busy = 1'b1;
        end
      end
      prev_hold = inst_valid && !inst_ready && !clear;
      prev_inst = inst;
    end
  end

  task automatic send_cmd(input int n, input logic [7:0] row, input logic [7:0] col,
                          input logic la, input logic st, input logic bias);
    logic acc;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_num_step = 16'(n); cmd_row_mask = row; cmd_col_mask = col;
    cmd_load_acc = la; cmd_store = st; cmd_bias = bias;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", acc, 1'b1);
  endtask

  task automatic wait_idle(input bit rand_ready, input bit rand_clear);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(posedge clk); #1;
      inst_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      clear = rand_clear && busy && ($urandom_range(0, 59) == 0);
      @(negedge clk);
      idle = !busy && !inst_valid && !clear;
    end
    @(posedge clk); #1;
    clear = 1'b0;
    inst_ready = 1'b1;
    check("idle_reached", idle, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // T1: back-to-back 4 steps, pinned first and last inst.
    send_cmd(4, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("t1_k0", inst, 22'h3FC04B);
    repeat (3) @(negedge clk); check("t1_k3", inst, 22'h3FC067);
    @(negedge clk); check("t1_done", done, 1'b1);

    // T2: stall 5 cycles on k1.
    send_cmd(3, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1 inst_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 inst_ready = 1'b1;
    wait_idle(1'b0, 1'b0);

    // T3: single step carries every flag.
    send_cmd(1, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("t3_inst", inst, 22'h294F2F);
    @(negedge clk); check("t3_done", done, 1'b1);

    // T4: zero steps.
    send_cmd(0, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("t4_done", done, 1'b1); check("t4_cmd_ready", cmd_ready, 1'b1);

    // T5: clear mid-tile.
    send_cmd(8, 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk); check("t5_valid", inst_valid, 1'b0);
    @(negedge clk); check("t5_no_done", done, 1'b0);
    send_cmd(2, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0);
    wait_idle(1'b0, 1'b0);

`ifdef DCA_STEP_GEN_BIAS_PRELOAD_EN
    // T6: bias preload ahead of two steps.
    send_cmd(2, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); check("t6_preload", inst, 22'h03FC18);
    wait_idle(1'b0, 1'b0);
`endif

    // Randomized tiles with back-pressure and occasional aborts.
    for (int c = 0; c < 60; c++) begin
      send_cmd(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9)),
               8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      wait_idle(1'b1, 1'b1);
    end

    // Asynchronous reset mid-tile.
    send_cmd(6, 8'h77, 8'h88, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1 check("arst_valid", inst_valid, 1'b0); check("arst_busy", busy, 1'b0); check("arst_inst", inst, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_cmd(3, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
    wait_idle(1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
